// File: rtl/result_checker.sv
// result_checker: arms on a job, watches finish with a cycle-budget watchdog, then streams
// banked output SRAM against golden memory with a programmable +/- tolerance.
module result_checker #(
  parameter int NUM_BANK   = 6,
  parameter int BANK_WORDS = 32768,
  parameter int MEM_W      = 16,
  parameter int DATA_W     = 8,
  parameter int GOLD_W     = 16,
  parameter int MAX_CYCLE  = 300,
  parameter int DRAIN_CYC  = 2,
  parameter int ERR_W      = 16,
  parameter int IDX_W      = $clog2(NUM_BANK*BANK_WORDS)+1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          arm_i,
  input  logic                          finish_i,
  input  logic [IDX_W-1:0]              word_num_i,
  input  logic [3:0]                    tol_i,
  output logic [NUM_BANK-1:0]           out_cs_o,
  output logic [$clog2(BANK_WORDS)-1:0] out_addr_o,
  input  logic [NUM_BANK*MEM_W-1:0]     out_rdata_i,
  output logic                          gold_cs_o,
  output logic [IDX_W-1:0]              gold_addr_o,
  input  logic [GOLD_W-1:0]             gold_rdata_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          timeout_o,
  output logic [ERR_W-1:0]              err_cnt_o,
  output logic [IDX_W-1:0]              first_err_idx_o,
  output logic                          first_err_vld_o
);
  localparam int AW = $clog2(BANK_WORDS);
  localparam int CW = $clog2(MAX_CYCLE+1);
  localparam int DW = $clog2(DRAIN_CYC+1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]          r_state;
  logic [IDX_W-1:0]    r_n, r_idx, r_cmp_idx, r_first_idx;
  logic [3:0]          r_tol;
  logic [CW-1:0]       r_cyc;
  logic [DW-1:0]       r_drain;
  logic [NUM_BANK-1:0] r_cmp_bank;
  logic                r_cmp_vld, r_timeout, r_first_vld;
  logic [ERR_W-1:0]    r_err;
  logic                w_issue, w_mis, w_unused;
  logic [NUM_BANK-1:0] w_bank_sel;
  logic [MEM_W-1:0]    w_lane;
  logic [GOLD_W:0]     w_out, w_gold, w_diff, w_abs;
  assign w_issue     = r_state == S_CHECK && r_idx < r_n;
  assign w_bank_sel  = NUM_BANK'(1) << (r_idx >> AW);
  assign out_cs_o    = w_issue ? w_bank_sel : '0;
  assign out_addr_o  = w_issue ? r_idx[AW-1:0] : '0;
  assign gold_cs_o   = w_issue;
  assign gold_addr_o = w_issue ? r_idx : '0;
  // The bank select registered with the read picks the lane that returns one cycle later
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NUM_BANK; k++)
      w_lane = w_lane | (r_cmp_bank[k] ? out_rdata_i[k*MEM_W +: MEM_W] : '0);
  end
  assign w_unused = ^w_lane[MEM_W-1:DATA_W];
  assign w_out    = {{(GOLD_W+1-DATA_W){w_lane[DATA_W-1]}}, w_lane[DATA_W-1:0]};
  assign w_gold   = {gold_rdata_i[GOLD_W-1], gold_rdata_i};
  assign w_diff   = w_out - w_gold;
  assign w_abs    = w_diff[GOLD_W] ? -w_diff : w_diff;
  assign w_mis    = r_cmp_vld && w_abs > (GOLD_W+1)'(r_tol);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_cmp_idx   <= '0;
      r_first_idx <= '0;
      r_tol       <= '0;
      r_cyc       <= '0;
      r_drain     <= '0;
      r_cmp_bank  <= '0;
      r_cmp_vld   <= 1'b0;
      r_timeout   <= 1'b0;
      r_first_vld <= 1'b0;
      r_err       <= '0;
    end else begin
      r_cmp_vld  <= w_issue;
      r_cmp_bank <= out_cs_o;
      r_cmp_idx  <= r_idx;
      if (w_mis) begin
        r_err <= &r_err ? r_err : r_err + 1'b1;
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_cmp_idx;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: if (arm_i) begin
          r_n         <= word_num_i;
          r_tol       <= tol_i;
          r_err       <= '0;
          r_timeout   <= 1'b0;
          r_first_vld <= 1'b0;
          r_first_idx <= '0;
          r_cyc       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_cyc <= r_cyc + 1'b1;
          // finish has priority over the budget expiring in the same cycle
          if (finish_i || r_cyc == CW'(MAX_CYCLE-1)) begin
            r_timeout <= !finish_i;
            r_drain   <= '0;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == DW'(DRAIN_CYC-1)) begin
            r_idx   <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: if (w_issue) r_idx <= r_idx + 1'b1; else r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy_o          = r_state inside {S_WAIT, S_DRAIN, S_CHECK};
  assign done_o          = r_state == S_DONE;
  assign pass_o          = done_o && r_err == '0 && !r_timeout;
  assign timeout_o       = r_timeout;
  assign err_cnt_o       = r_err;
  assign first_err_idx_o = r_first_idx;
  assign first_err_vld_o = r_first_vld;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: scoreboard bench with small banks; a second instance with a 2-bit
// error counter shares all inputs to exercise saturation.
module tb_result_checker;
  localparam int NB = 3, BW = 4, MW = 16, DW = 8, GW = 16, MC = 300, DC = 2, EW = 8;
  localparam int IW = $clog2(NB*BW)+1;
  localparam int AW = $clog2(BW);
  typedef struct {int n; int err; bit fv; int fi; bit to;} res_t;
  logic clk = 0, rstn = 0, arm_i = 0, finish_i = 0;
  logic [IW-1:0] word_num_i = '0;
  logic [3:0] tol_i = '0;
  logic [NB-1:0] out_cs_o, cs_b;
  logic [AW-1:0] out_addr_o, addr_b;
  logic [NB*MW-1:0] out_rdata_i = '0;
  logic gold_cs_o, gcs_b;
  logic [IW-1:0] gold_addr_o, gaddr_b, first_err_idx_o, fidx_b;
  logic [GW-1:0] gold_rdata_i = '0;
  logic busy_o, done_o, pass_o, timeout_o, first_err_vld_o;
  logic busy_b, done_b, pass_b, to_b, fvld_b;
  logic [EW-1:0] err_cnt_o;
  logic [1:0] err_b;
  logic [MW-1:0] bank_mem [NB][BW];
  logic [GW-1:0] gold_mem [NB*BW];
  res_t res_q[$];
  int iss_q[$];
  int n_chk = 0, n_err = 0;
  bit prev_iss = 0;

  result_checker #(.NUM_BANK(NB), .BANK_WORDS(BW), .MEM_W(MW), .DATA_W(DW), .GOLD_W(GW),
    .MAX_CYCLE(MC), .DRAIN_CYC(DC), .ERR_W(EW), .IDX_W(IW)) u_dut (
    .clk(clk), .rstn(rstn), .arm_i(arm_i), .finish_i(finish_i), .word_num_i(word_num_i),
    .tol_i(tol_i), .out_cs_o(out_cs_o), .out_addr_o(out_addr_o), .out_rdata_i(out_rdata_i),
    .gold_cs_o(gold_cs_o), .gold_addr_o(gold_addr_o), .gold_rdata_i(gold_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o), .first_err_vld_o(first_err_vld_o));

  result_checker #(.NUM_BANK(NB), .BANK_WORDS(BW), .MEM_W(MW), .DATA_W(DW), .GOLD_W(GW),
    .MAX_CYCLE(MC), .DRAIN_CYC(DC), .ERR_W(2), .IDX_W(IW)) u_sat (
    .clk(clk), .rstn(rstn), .arm_i(arm_i), .finish_i(finish_i), .word_num_i(word_num_i),
    .tol_i(tol_i), .out_cs_o(cs_b), .out_addr_o(addr_b), .out_rdata_i(out_rdata_i),
    .gold_cs_o(gcs_b), .gold_addr_o(gaddr_b), .gold_rdata_i(gold_rdata_i),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(to_b),
    .err_cnt_o(err_b), .first_err_idx_o(fidx_b), .first_err_vld_o(fvld_b));

  always #5 clk = ~clk;

  // Registered-read memories; unselected lanes return noise so lane choice matters
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++)
      out_rdata_i[k*MW +: MW] <= out_cs_o[k] ? bank_mem[k][out_addr_o] : MW'($urandom);
    gold_rdata_i <= gold_cs_o ? gold_mem[gold_addr_o] : GW'($urandom);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) prev_iss = 0;
    else if (gold_cs_o || |out_cs_o) begin
      if (iss_q.size() == 0) chk("spurious_issue", int'(gold_addr_o), -1);
      else begin
        int e;
        e = iss_q.pop_front();
        chk("gold_addr", int'(gold_addr_o), e);
        chk("gold_cs", int'(gold_cs_o), 1);
        chk("out_cs", int'(out_cs_o), 1 << (e / BW));
        chk("out_addr", int'(out_addr_o), e % BW);
        chk("no_bubble", int'(prev_iss || e == 0), 1);
      end
      prev_iss = 1;
    end else prev_iss = 0;
  end

  task automatic put(input int i, input int o, input int g);
    bank_mem[i / BW][i % BW] = {8'($urandom), 8'(o)};
    gold_mem[i] = 16'(g);
  endtask

  task automatic fill_clean();
    for (int i = 0; i < NB*BW; i++) begin
      int o;
      o = int'($urandom_range(0, 255)) - 128;
      put(i, o, o);
    end
  endtask

  task automatic run_job(input int n, input int tol, input int fin, input bit mid_arm);
    res_t r;
    int j;
    r.n = n; r.err = 0; r.fv = 0; r.fi = 0; r.to = fin < 0;
    for (int i = 0; i < n; i++) begin
      int o, g, d;
      o = int'($signed(bank_mem[i / BW][i % BW][DW-1:0]));
      g = int'($signed(gold_mem[i]));
      d = o - g;
      if (d < 0) d = -d;
      if (d > tol) begin
        if (!r.fv) begin r.fv = 1; r.fi = i; end
        r.err++;
      end
      iss_q.push_back(i);
    end
    res_q.push_back(r);
    @(negedge clk); arm_i = 1; word_num_i = IW'(n); tol_i = 4'(tol);
    @(negedge clk); arm_i = 0; word_num_i = IW'(n + 3); tol_i = 4'hF;
    if (fin < 0) begin
      repeat (MC - 1) @(negedge clk);
      chk("timeout_pre", int'(timeout_o), 0);
      @(negedge clk);
      chk("timeout_fire", int'(timeout_o), 1);
    end else begin
      repeat (fin) @(negedge clk);
      finish_i = 1;
      @(negedge clk); finish_i = 0;
      chk("timeout_clear", int'(timeout_o), 0);
    end
    chk("busy", int'(busy_o), 1);
    j = 0;
    while (!done_o && j < 200) begin
      @(negedge clk);
      j++;
      arm_i = mid_arm && j == 2;
      if (arm_i) word_num_i = IW'(2);
    end
    arm_i = 0;
    chk("done_latency", j, n + 3);
    r = res_q.pop_front();
    chk("done", int'(done_o), 1);
    chk("busy_done", int'(busy_o), 0);
    chk("pass", int'(pass_o), int'(r.err == 0 && !r.to));
    chk("err_cnt", int'(err_cnt_o), r.err);
    chk("err_sat", int'(err_b), r.err > 3 ? 3 : r.err);
    chk("first_vld", int'(first_err_vld_o), int'(r.fv));
    if (r.fv) chk("first_idx", int'(first_err_idx_o), r.fi);
    chk("timeout", int'(timeout_o), int'(r.to));
    chk("issues_left", iss_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("hold_err", int'(err_cnt_o), r.err);
    chk("hold_done", int'(done_o), 1);
  endtask

  initial begin
    for (int i = 0; i < NB*BW; i++) put(i, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_out_cs", int'(out_cs_o), 0);
    chk("rst_gold_cs", int'(gold_cs_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pass", int'(pass_o), 0);
    chk("rst_err", int'(err_cnt_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    chk("rst_first_vld", int'(first_err_vld_o), 0);
    rstn = 1;
    @(negedge clk);
    // clean pass
    fill_clean();
    run_job(10, 0, 50, 0);
    // tolerance boundary
    fill_clean();
    put(0, 'h7F, 'h7E);
    put(1, -128, -126);
    put(2, -128, -127);
    put(3, 5, 6);
    run_job(4, 1, 7, 0);
    // bank crossing with mismatches at 3, 4, 9
    fill_clean();
    put(3, 10, 15);
    put(4, -50, -60);
    put(9, 0, 100);
    run_job(10, 0, 20, 0);
    // watchdog expiry
    fill_clean();
    run_job(5, 0, -1, 0);
    // finish on the last budget cycle, plus an arm during CHECK
    run_job(10, 0, MC - 1, 1);
    // reset in the middle of CHECK
    put(3, 10, 15);
    put(4, -50, -60);
    for (int i = 0; i < 10; i++) iss_q.push_back(i);
    @(negedge clk); arm_i = 1; word_num_i = IW'(10); tol_i = 4'd0;
    @(negedge clk); arm_i = 0;
    repeat (2) @(negedge clk);
    finish_i = 1;
    @(negedge clk); finish_i = 0;
    repeat (8) @(negedge clk);
    chk("pre_rst_err", int'(err_cnt_o), 2);
    rstn = 0;
    @(negedge clk);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_err", int'(err_cnt_o), 0);
    chk("midrst_first_vld", int'(first_err_vld_o), 0);
    chk("midrst_out_cs", int'(out_cs_o), 0);
    chk("midrst_gold_cs", int'(gold_cs_o), 0);
    chk("midrst_done", int'(done_o), 0);
    rstn = 1;
    iss_q.delete();
    @(negedge clk);
    chk("post_rst_busy", int'(busy_o), 0);
    chk("post_rst_done", int'(done_o), 0);
    // empty job
    run_job(0, 0, 3, 0);
    // saturation of the narrow counter
    fill_clean();
    for (int i = 0; i < 5; i++) put(i, i, i + 20);
    run_job(6, 2, 4, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
